// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
// The fetch step also picks up its reset PC from here.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision: data wins unless fetch has been starved
// for the maximum number of consecutive data grants.
module mem_arb_pick #(
  parameter int SW = 3
) (
  input  logic          f_req_i,
  input  logic          d_req_i,
  input  logic [SW-1:0] streak_i,
  input  logic [SW-1:0] max_i,
  output logic          grant_f_o,
  output logic          grant_d_o
);

  logic f_forced;

  assign f_forced  = f_req_i && (streak_i == max_i);
  assign grant_d_o = d_req_i && !f_forced;
  assign grant_f_o = f_req_i && !grant_d_o;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between fetch (read-only) and data
// (read/write) requesters with an IDLE/BUSY/DONE handshake.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                f_req_i,
  input  logic [ADDR_W-1:0]   f_addr_i,
  output logic                f_done_o,
  output logic [DATA_W-1:0]   f_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_done_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam int BW = DATA_W / 8;
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  state_e            state_q;
  owner_e            owner_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BW-1:0]     wstrb_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
  logic              f_done_q, d_done_q;
  logic              pick_f, pick_d;
  logic              grant_f, grant_d, idle;

  mem_arb_pick #(.SW(SW)) u_pick (
    .f_req_i   (f_req_i),
    .d_req_i   (d_req_i),
    .streak_i  (streak_q),
    .max_i     (STREAK_MAX),
    .grant_f_o (pick_f),
    .grant_d_o (pick_d)
  );

  assign idle    = (state_q == IDLE);
  assign grant_f = idle && pick_f;
  assign grant_d = idle && pick_d;

  // Streak only counts data grants that actually kept fetch waiting.
  always_comb begin
    streak_d = streak_q;
    if (grant_f)
      streak_d = '0;
    else if (grant_d && f_req_i && streak_q != STREAK_MAX)
      streak_d = streak_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_F;
      streak_q  <= '0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
      streak_q <= streak_d;
      unique case (state_q)
        IDLE: begin
          if (grant_f || grant_d) begin
            state_q   <= BUSY;
            mem_req_q <= 1'b1;
            owner_q   <= grant_d ? OWNER_D : OWNER_F;
            addr_q    <= grant_d ? d_addr_i : f_addr_i;
            we_q      <= grant_d && d_we_i;
            wdata_q   <= grant_d ? d_wdata_i : '0;
            wstrb_q   <= grant_d ? d_wstrb_i : '0;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (owner_q == OWNER_D) begin
              d_done_q <= 1'b1;
              if (!we_q) d_rdata_q <= mem_rdata_i;
            end else begin
              f_done_q <= 1'b1;
              if (!we_q) f_rdata_q <= mem_rdata_i;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_done_o    = f_done_q;
  assign d_done_o    = d_done_q;
  assign f_rdata_o   = f_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed cycle-exact bench for imem_dmem_arbiter.
// Inputs driven and outputs sampled 1 time unit after posedge.
module tb_imem_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_done_o;
  logic [31:0] f_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_wstrb_i;
  logic        d_done_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  imem_dmem_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .f_req_i     (f_req_i),
    .f_addr_i    (f_addr_i),
    .f_done_o    (f_done_o),
    .f_rdata_o   (f_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_wstrb_i   (d_wstrb_i),
    .d_done_o    (d_done_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b0;
    f_req_i     = 1'b0;
    f_addr_i    = '0;
    d_req_i     = 1'b0;
    d_we_i      = 1'b0;
    d_addr_i    = '0;
    d_wdata_i   = '0;
    d_wstrb_i   = '0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0000_0513;

    tick(); tick();
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_f_done",  64'(f_done_o),  64'd0);
    check("rst_d_done",  64'(d_done_o),  64'd0);
    check("rst_f_rdata", 64'(f_rdata_o), 64'd0);
    check("rst_d_rdata", 64'(d_rdata_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // F only
    f_req_i  = 1'b1;
    f_addr_i = 32'h8000_0000;
    tick();
    check("t1_mem_req",  64'(mem_req_o),  64'd1);
    check("t1_mem_addr", 64'(mem_addr_o), 64'h8000_0000);
    check("t1_mem_we",   64'(mem_we_o),   64'd0);
    tick();
    check("t1_f_done",   64'(f_done_o),   64'd1);
    check("t1_f_rdata",  64'(f_rdata_o),  64'h0000_0513);
    check("t1_d_done",   64'(d_done_o),   64'd0);
    check("t1_req_off",  64'(mem_req_o),  64'd0);
    f_req_i = 1'b0;
    tick();

    // F and D together, D store goes first
    mem_rdata_i = 32'h1111_2222;
    f_req_i   = 1'b1;
    f_addr_i  = 32'h8000_0004;
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h8000_1000;
    d_wdata_i = 32'hDEAD_BEEF;
    d_wstrb_i = 4'b0011;
    tick();
    check("t2_mem_we",    64'(mem_we_o),    64'd1);
    check("t2_mem_wstrb", 64'(mem_wstrb_o), 64'h3);
    check("t2_mem_addr",  64'(mem_addr_o),  64'h8000_1000);
    check("t2_mem_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    tick();
    check("t2_d_done",  64'(d_done_o),  64'd1);
    check("t2_f_done0", 64'(f_done_o),  64'd0);
    check("t2_d_rdata", 64'(d_rdata_o), 64'd0);
    d_req_i = 1'b0;
    d_we_i  = 1'b0;
    tick();
    check("t2_idle_req", 64'(mem_req_o), 64'd0);
    tick();
    check("t2_f_addr",  64'(mem_addr_o),  64'h8000_0004);
    check("t2_f_we",    64'(mem_we_o),    64'd0);
    check("t2_f_wstrb", 64'(mem_wstrb_o), 64'h0);
    tick();
    check("t2_f_done",  64'(f_done_o),  64'd1);
    check("t2_f_rdata", 64'(f_rdata_o), 64'h1111_2222);
    f_req_i = 1'b0;
    tick();

    // Both held: four D grants, then one F, repeating
    f_req_i  = 1'b1;
    d_req_i  = 1'b1;
    d_we_i   = 1'b0;
    d_addr_i = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_busy", 64'(mem_req_o), 64'd1);
      tick();
      check("t3_d_done", 64'(d_done_o), 64'((i % 5) != 4));
      check("t3_f_done", 64'(f_done_o), 64'((i % 5) == 4));
      if (i == 9) begin
        f_req_i = 1'b0;
        d_req_i = 1'b0;
      end
      tick();
    end
    check("t3_idle", 64'(mem_req_o), 64'd0);

    // D read with five memory wait cycles
    mem_ready_i = 1'b0;
    d_req_i     = 1'b1;
    d_addr_i    = 32'h0000_2040;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_wait_req",  64'(mem_req_o),  64'd1);
      check("t4_wait_addr", 64'(mem_addr_o), 64'h0000_2040);
      check("t4_wait_done", 64'(d_done_o),   64'd0);
      if (i < 4) tick();
    end
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    tick();
    check("t4_d_done",  64'(d_done_o),  64'd1);
    check("t4_d_rdata", 64'(d_rdata_o), 64'hCAFE_F00D);
    check("t4_f_rdata", 64'(f_rdata_o), 64'h1111_2222);
    d_req_i = 1'b0;
    tick();

    // Async reset in the middle of BUSY
    mem_ready_i = 1'b0;
    f_req_i     = 1'b1;
    f_addr_i    = 32'h8000_0008;
    tick();
    check("t5_busy", 64'(mem_req_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("t5_rst_req",     64'(mem_req_o), 64'd0);
    check("t5_rst_f_done",  64'(f_done_o),  64'd0);
    check("t5_rst_d_done",  64'(d_done_o),  64'd0);
    check("t5_rst_f_rdata", 64'(f_rdata_o), 64'd0);
    check("t5_rst_d_rdata", 64'(d_rdata_o), 64'd0);
    f_req_i     = 1'b0;
    mem_ready_i = 1'b1;
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_quiet_f", 64'(f_done_o),  64'd0);
      check("t5_quiet_d", 64'(d_done_o),  64'd0);
      check("t5_quiet_r", 64'(mem_req_o), 64'd0);
    end
    mem_rdata_i = 32'h0000_0093;
    f_req_i     = 1'b1;
    tick();
    check("t5_new_addr", 64'(mem_addr_o), 64'h8000_0008);
    tick();
    check("t5_new_done",  64'(f_done_o),  64'd1);
    check("t5_new_rdata", 64'(f_rdata_o), 64'h0000_0093);
    f_req_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single 32-bit memory port between the fetch step (read-only requester F) and the memory step (read/write requester D).
- Arbitrates between the two requesters, latches the winner's command and drives the memory-side req/ready handshake.
- Returns read data and a one-cycle done pulse to the owner.
- Sits between the pipeline steps and the memory model. The fetch step's mem_address_o and instruction_i connect through the F port instead of wiring directly to memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.
- DATA_STREAK_MAX, 4, number of consecutive D grants allowed while F waits before F is forced ahead.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- f_req_i  in  1  fetch request; held until f_done_o.
- f_addr_i  in  ADDR_W  fetch address.
- f_done_o  out  1  fetch complete, one-cycle pulse.
- f_rdata_o  out  DATA_W  fetched word; valid with f_done_o, held until the next F read.
- d_req_i  in  1  data request; held until d_done_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  write data.
- d_wstrb_i  in  DATA_W/8  byte enables for writes.
- d_done_o  out  1  data access complete, one-cycle pulse.
- d_rdata_o  out  DATA_W  load data; valid with d_done_o, held until the next D read.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_wstrb_o  out  DATA_W/8  memory byte enables.
- mem_ready_i  in  1  memory accepted/completed the access this cycle.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ready_i=1 and mem_we_o=0.

Behaviour:
- Reset (rst_i=0, async):
  - state = IDLE, owner = F, streak = 0.
  - All outputs 0, including f_rdata_o and d_rdata_o.
  - Any in-flight access is abandoned and no done pulse is issued. Requesters must re-request after reset.
- IDLE:
  - No request pending: stay in IDLE, mem_req_o = 0.
  - Only one of f_req_i / d_req_i high: grant that requester.
  - Both high: grant D, unless streak == DATA_STREAK_MAX, in which case grant F.
  - On grant: latch addr/we/wdata/wstrb (F forces we=0, wstrb=0), record the owner, go to BUSY.
- streak counter (width clog2(DATA_STREAK_MAX+1)):
  - Increments (saturating) on a D grant while f_req_i=1.
  - Clears on any F grant.
  - Otherwise holds.
- BUSY:
  - mem_req_o = 1 and mem_* are driven from registered latched values, stable for the whole of BUSY.
  - Stays in BUSY while mem_ready_i = 0. There is no timeout.
  - On a cycle with mem_ready_i = 1:
    - For a read, register mem_rdata_i into the owner's rdata_o.
    - For a write, rdata_o is unchanged.
    - Go to DONE.
- DONE:
  - The owner's done_o = 1 for exactly this cycle. mem_req_o = 0. No grant is made.
  - Next state is IDLE.
  - Requesters must drop req at the edge where they sample done_o = 1. This guarantees no duplicate grant.
- Latency:
  - Requests sampled in IDLE at cycle n give mem_req_o = 1 in cycle n+1.
  - With mem_ready_i=1 in cycle n+1, done_o = 1 in cycle n+2. Minimum latency is 2 cycles; +1 per memory wait cycle.
- Throughput: at most one access per 3 cycles (IDLE, BUSY, DONE).
- Address is passed through unmodified. Alignment is the requester's responsibility and no error is flagged.
- A req_i falling while its access is BUSY is ignored. The access completes and done_o still pulses.
- f_done_o and d_done_o are never high together.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Owner encoding {OWNER_F=0, OWNER_D=1}.
  - Defaults for ADDR_W, DATA_W and RESET_PC (32'h8000_0000), reused by the fetch step.
- Sub-module mem_arb_pick: combinational priority/streak decision (f_req, d_req, streak, max -> grant_f, grant_d). This keeps the fairness rule separately testable.

Test Plan:
- F only, addr 32'h8000_0000, mem_ready_i tied 1, mem_rdata_i 32'h0000_0513:
  - mem_req_o=1 with addr 32'h8000_0000 in cycle 1.
  - f_done_o=1 and f_rdata_o=32'h0000_0513 in cycle 2.
  - d_done_o stays 0.
- F and D asserted in the same cycle, D store addr 32'h8000_1000, wdata 32'hDEAD_BEEF, wstrb 4'b0011:
  - D served first: mem_we_o=1, mem_wstrb_o=4'b0011, no change to d_rdata_o.
  - F served immediately after, with f_done_o 3 cycles after d_done_o.
- Both held continuously, D re-requesting right after each done:
  - Exactly 4 consecutive D grants, then 1 F grant; the pattern repeats and streak clears.
- mem_ready_i held 0 for 5 cycles during a D read:
  - mem_addr_o and mem_req_o are stable for all 5 cycles.
  - d_done_o follows 1 cycle after mem_ready_i rises, with d_rdata_o equal to mem_rdata_i at that cycle.
- rst_i pulled low asynchronously mid-BUSY:
  - mem_req_o, f_done_o, d_done_o, f_rdata_o and d_rdata_o drop to 0 before the next clock edge.
  - After rst_i rises, no done pulse appears until a new request is made.
